// File: rtl/receiver_reader_mc.sv
// receiver_reader_mc: multi-channel RC receiver PWM pulse-width reader.
// Each channel measures its high time in prescaler ticks, removes the 1 ms
// offset, saturates to OUT_W bits and strobes pwm_valid on every accepted pulse.
// A per-channel timeout raises link_lost when no pulse is accepted for a while.
// Optional feature macro: RECEIVER_FAILSAFE_EN (loads FAILSAFE_VAL on link loss).
module receiver_reader_mc #(
    parameter int NUM_CH        = 4,
    parameter int OUT_W         = 8,
    parameter int DIV           = 1330,
    parameter int OFFSET        = 40,
    parameter int MAX_TICKS     = 120,
    parameter int TIMEOUT_TICKS = 2000
`ifdef RECEIVER_FAILSAFE_EN
    ,
    parameter int FAILSAFE_VAL  = 0
`endif
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_CH-1:0]       pwm_in,
    output logic [NUM_CH*OUT_W-1:0] pwm_out,
    output logic [NUM_CH-1:0]       pwm_valid,
    output logic [NUM_CH-1:0]       link_lost
);

    localparam int CW = OUT_W + 2;
    localparam int PW = $clog2(DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [PW-1:0] DIV_LAST_C = PW'(DIV - 1);
    localparam logic [CW-1:0] OFFSET_C   = CW'(OFFSET);
    localparam logic [CW-1:0] MAX_C      = CW'(MAX_TICKS);
    localparam logic [CW-1:0] SAT_C      = CW'((1 << OUT_W) - 1);
    localparam logic [TW-1:0] TMO_C      = TW'(TIMEOUT_TICKS);
    localparam logic [TW-1:0] TMO_LAST_C = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        WAIT_LOW,
        LOW,
        HIGH,
        ERR
    } state_t;

    logic [1:0]        rstSync_q;
    logic              rstInt_n;
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [PW-1:0]     presc_q;
    logic              tick;

    // Internal reset: asserts immediately with sys_rst_n, releases two clocks later
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rstSync_q <= 2'b00;
        end else begin
            rstSync_q <= {rstSync_q[0], 1'b1};
        end
    end

    assign rstInt_n = rstSync_q[1];

    // Two-flop synchronizer per PWM line plus one more stage for edge detection
    always_ff @(posedge sys_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    // Shared prescaler producing a one-cycle tick every DIV clocks
    always_ff @(posedge sys_clk or negedge rstInt_n) begin
        if (!rstInt_n) begin
            presc_q <= '0;
        end else if (presc_q == DIV_LAST_C) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = (presc_q == DIV_LAST_C);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        state_t           state_q;
        logic [CW-1:0]    cnt_q;
        logic [TW-1:0]    tmo_q;
        logic             lost_q;
        logic             valid_q;
        logic [OUT_W-1:0] out_q;
        logic [CW-1:0]    cntEff_d;
        logic [CW-1:0]    diff_d;
        logic [OUT_W-1:0] satVal_d;
        logic             accept_d;

        // A tick landing on the falling-edge cycle still belongs to the pulse,
        // so an H-tick-long high time always measures exactly H
        assign cntEff_d = cnt_q + {{(CW-1){1'b0}}, tick};
        assign diff_d   = cntEff_d - OFFSET_C;
        assign satVal_d = (diff_d > SAT_C) ? '1 : diff_d[OUT_W-1:0];
        assign accept_d = (state_q == HIGH) && fall[n] && (cntEff_d > OFFSET_C);

        // Channel FSM, pulse measurement, timeout tracking and registered outputs
        always_ff @(posedge sys_clk or negedge rstInt_n) begin
            if (!rstInt_n) begin
                state_q <= WAIT_LOW;
                cnt_q   <= '0;
                tmo_q   <= '0;
                lost_q  <= 1'b1;
                valid_q <= 1'b0;
                out_q   <= '0;
            end else begin
                valid_q <= 1'b0;
                case (state_q)
                    WAIT_LOW: begin
                        if (!sync2_q[n]) begin
                            state_q <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise[n]) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                        end
                    end
                    HIGH: begin
                        if (fall[n]) begin
                            state_q <= LOW;
                            if (accept_d) begin
                                out_q   <= satVal_d;
                                valid_q <= 1'b1;
                            end
                        end else if (cnt_q >= MAX_C) begin
                            state_q <= ERR;
                        end else if (tick) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ERR: begin
                        if (!sync2_q[n]) begin
                            state_q <= LOW;
                        end
                    end
                    default: begin
                        state_q <= WAIT_LOW;
                    end
                endcase

                if (accept_d) begin
                    tmo_q  <= '0;
                    lost_q <= 1'b0;
                end else if (tick && (tmo_q != TMO_C)) begin
                    tmo_q <= tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST_C) begin
                        lost_q <= 1'b1;
`ifdef RECEIVER_FAILSAFE_EN
                        if (!lost_q) begin
                            out_q   <= OUT_W'(FAILSAFE_VAL);
                            valid_q <= 1'b1;
                        end
`endif
                    end
                end
            end
        end

        assign pwm_out[n*OUT_W +: OUT_W] = out_q;
        assign pwm_valid[n]              = valid_q;
        assign link_lost[n]              = lost_q;
    end

endmodule

// File: tb/tb_receiver_reader_mc.sv
// tb_receiver_reader_mc: scoreboard bench for receiver_reader_mc.
// Stimulus pushes the expected strobe values per channel; a negedge monitor
// pops and compares whenever pwm_valid fires. A second narrow instance
// (OUT_W=4) covers output saturation.
module tb_receiver_reader_mc;

    localparam int NUM_CH = 4;
    localparam int OUT_W  = 8;
    localparam int DIV    = 10;

    typedef struct {
        int val;
        bit lostChk;
    } expEntry_t;

    logic                    sysClk;
    logic                    rstN;
    logic [NUM_CH-1:0]       pwmIn;
    logic [NUM_CH*OUT_W-1:0] pwmOut;
    logic [NUM_CH-1:0]       pwmValid;
    logic [NUM_CH-1:0]       linkLost;

    logic [0:0]              pwmInS;
    logic [3:0]              pwmOutS;
    logic [0:0]              pwmValidS;
    logic [0:0]              linkLostS;

    expEntry_t expQ [NUM_CH][$];
    int        expQS [$];
    expEntry_t monEntry;
    int        monVal;
    int        checks = 0;
    int        errors = 0;

    receiver_reader_mc #(
        .NUM_CH (NUM_CH),
        .OUT_W  (OUT_W),
        .DIV    (DIV)
    ) dut (
        .sys_clk   (sysClk),
        .sys_rst_n (rstN),
        .pwm_in    (pwmIn),
        .pwm_out   (pwmOut),
        .pwm_valid (pwmValid),
        .link_lost (linkLost)
    );

    receiver_reader_mc #(
        .NUM_CH    (1),
        .OUT_W     (4),
        .DIV       (DIV),
        .MAX_TICKS (62)
    ) dutNarrow (
        .sys_clk   (sysClk),
        .sys_rst_n (rstN),
        .pwm_in    (pwmInS),
        .pwm_out   (pwmOutS),
        .pwm_valid (pwmValidS),
        .link_lost (linkLostS)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        sysClk = 1'b0;
        forever #5 sysClk = ~sysClk;
    end

    // Monitor: every strobe must match the oldest expectation for its channel
    always @(negedge sysClk) begin
        if (rstN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pwmValid[c]) begin
                    monVal = int'(pwmOut[c*OUT_W +: OUT_W]);
                    checks++;
                    if (expQ[c].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL strobe_ch%0d: unexpected strobe with value %0d, required no strobe", c, monVal);
                    end else begin
                        monEntry = expQ[c].pop_front();
                        if (monVal != monEntry.val) begin
                            errors++;
                            $display("[TB] FAIL value_ch%0d: got %0d, required %0d", c, monVal, monEntry.val);
                        end
                        if (monEntry.lostChk) begin
                            checks++;
                            if (linkLost[c] !== 1'b0) begin
                                errors++;
                                $display("[TB] FAIL lost_clear_ch%0d: link_lost %0b at strobe, required 0", c, linkLost[c]);
                            end
                        end
                    end
                end
            end
            if (pwmValidS[0]) begin
                checks++;
                if (expQS.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL strobe_narrow: unexpected strobe with value %0d, required no strobe", pwmOutS);
                end else begin
                    monVal = expQS.pop_front();
                    if (int'(pwmOutS) != monVal) begin
                        errors++;
                        $display("[TB] FAIL value_narrow: got %0d, required %0d", pwmOutS, monVal);
                    end
                end
            end
        end
    end

    // Direct comparison used for levels and held values
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Drive one high pulse of 'ticks' ticks on the channels in 'mask';
    // expVal < 0 means the pulse must not produce a strobe
    task automatic applyStimulus(input logic [NUM_CH-1:0] mask, input int ticks,
                                 input int expVal, input bit lostChk);
        expEntry_t e;
        e.val     = expVal;
        e.lostChk = lostChk;
        if (expVal >= 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask[c]) expQ[c].push_back(e);
            end
        end
        @(posedge sysClk); #1;
        pwmIn = pwmIn | mask;
        repeat (ticks * DIV) @(posedge sysClk);
        #1;
        pwmIn = pwmIn & ~mask;
        repeat (20) @(posedge sysClk);
    endtask

    // Same pulse generator for the narrow instance
    task automatic applyStimulusNarrow(input int ticks, input int expVal);
        if (expVal >= 0) expQS.push_back(expVal);
        @(posedge sysClk); #1;
        pwmInS = 1'b1;
        repeat (ticks * DIV) @(posedge sysClk);
        #1;
        pwmInS = 1'b0;
        repeat (20) @(posedge sysClk);
    endtask

    // Directed sequence
    initial begin
        pwmIn  = '0;
        pwmInS = '0;
        rstN   = 1'b0;
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        checkOutput("reset_out", int'(pwmOut), 0);
        checkOutput("reset_valid", int'(pwmValid), 0);
        checkOutput("reset_lost", int'(linkLost), 15);
        #1;
        rstN = 1'b1;
        repeat (10) @(posedge sysClk);

        // Nominal pulse, then offset rejection, then over-length error
        applyStimulus(4'b0001, 100, 60, 1'b1);
        @(negedge sysClk);
        checkOutput("lost_after_first", int'(linkLost[0]), 0);
        applyStimulus(4'b0001, 30, -1, 1'b0);
        @(negedge sysClk);
        checkOutput("hold_after_reject", int'(pwmOut[7:0]), 60);
        applyStimulus(4'b0001, 130, -1, 1'b0);
        @(negedge sysClk);
        checkOutput("hold_after_err", int'(pwmOut[7:0]), 60);
        applyStimulus(4'b0001, 90, 50, 1'b1);
        applyStimulus(4'b0001, 41, 1, 1'b1);

        // Signal loss on ch0
`ifdef RECEIVER_FAILSAFE_EN
        begin
            expEntry_t fs;
            fs.val     = 0;
            fs.lostChk = 1'b0;
            expQ[0].push_back(fs);
        end
`endif
        repeat (1990 * DIV) @(posedge sysClk);
        @(negedge sysClk);
        checkOutput("lost_before_timeout", int'(linkLost[0]), 0);
        repeat (20 * DIV) @(posedge sysClk);
        @(negedge sysClk);
        checkOutput("lost_after_timeout", int'(linkLost[0]), 1);
`ifdef RECEIVER_FAILSAFE_EN
        checkOutput("out_failsafe", int'(pwmOut[7:0]), 0);
`else
        checkOutput("out_hold_lost", int'(pwmOut[7:0]), 1);
`endif
        applyStimulus(4'b0001, 80, 40, 1'b1);

        // Simultaneous pulses on two channels
        applyStimulus(4'b1100, 80, 40, 1'b1);
        @(negedge sysClk);
        checkOutput("lost_vector", int'(linkLost), 2);

        // Reset in the middle of a ch1 pulse, released while ch1 is still high
        @(posedge sysClk); #1;
        pwmIn[1] = 1'b1;
        repeat (50 * DIV) @(posedge sysClk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_out", int'(pwmOut), 0);
        checkOutput("midreset_lost", int'(linkLost), 15);
        repeat (5) @(posedge sysClk);
        #1;
        rstN = 1'b1;
        repeat (40 * DIV) @(posedge sysClk);
        #1;
        pwmIn[1] = 1'b0;
        repeat (30) @(posedge sysClk);
        applyStimulus(4'b0010, 70, 30, 1'b1);
        @(negedge sysClk);
        checkOutput("lost_after_reset_pulse", int'(linkLost), 13);

        // Narrow instance: offset boundary, in-range value, saturation
        applyStimulusNarrow(40, -1);
        applyStimulusNarrow(50, 10);
        applyStimulusNarrow(60, 15);
        @(negedge sysClk);
        checkOutput("narrow_hold", int'(pwmOutS), 15);

        repeat (50) @(posedge sysClk);
        @(negedge sysClk);
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (expQ[c].size() != 0) begin
                errors++;
                $display("[TB] FAIL missing_strobe_ch%0d: %0d expected strobes never seen, required 0", c, expQ[c].size());
            end
        end
        checks++;
        if (expQS.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_strobe_narrow: %0d expected strobes never seen, required 0", expQS.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
